// File: rtl/reg_ctx_engine_pkg.sv
// Shared types and constants for the register context save/restore engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_ctx_engine_pkg;

  localparam int DATA_W   = 24;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 24;
  localparam int NUM_REGS = 15;

  // Architectural register indices (index 0 is the hard-wired zero register).
  localparam logic [IDX_W-1:0] REG_SP = 4'd1;
  localparam logic [IDX_W-1:0] REG_FP = 4'd2;
  localparam logic [IDX_W-1:0] REG_RA = 4'd3;
  localparam logic [IDX_W-1:0] REG_A0 = 4'd4;
  localparam logic [IDX_W-1:0] REG_A1 = 4'd5;
  localparam logic [IDX_W-1:0] REG_M0 = 4'd6;
  localparam logic [IDX_W-1:0] REG_M1 = 4'd7;
  localparam logic [IDX_W-1:0] REG_RV = 4'd8;
  localparam logic [IDX_W-1:0] REG_V0 = 4'd9;
  localparam logic [IDX_W-1:0] REG_V1 = 4'd10;
  localparam logic [IDX_W-1:0] REG_P0 = 4'd11;
  localparam logic [IDX_W-1:0] REG_P1 = 4'd12;
  localparam logic [IDX_W-1:0] REG_P2 = 4'd13;
  localparam logic [IDX_W-1:0] REG_P3 = 4'd14;
  localparam logic [IDX_W-1:0] REG_P4 = 4'd15;

  localparam logic OP_SAVE    = 1'b0;
  localparam logic OP_RESTORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAP,
    ST_MEM,
    ST_WB,
    ST_DONE
  } state_e;

  // One-hot mask bit for a register index; index 0 maps to no bit.
  function automatic logic [NUM_REGS-1:0] idx_bit(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] b;
    b = '0;
    if (idx != '0) b[idx - 4'd1] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/reg_ctx_engine_mask_pick.sv
// Picks the lowest (dir=0) or highest (dir=1) selected register index from a mask.
// Latency: purely combinational.
// Backpressure: none.
module reg_mask_pick
  import reg_ctx_engine_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic                dir,
  output logic [IDX_W-1:0]    index,
  output logic                any
);

  // Priority scan; the last hit in scan order wins, so scan away from the wanted end.
  always_comb begin
    index = '0;
    any   = |mask;
    if (dir) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (mask[i]) index = IDX_W'(i + 1);
      end
    end else begin
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
        if (mask[i]) index = IDX_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/reg_ctx_engine.sv
// Spills/refills masked general registers to/from a descending memory stack.
// Latency: done in cycle T+1+2n for n registers with zero-wait memory, +1 per ack wait cycle.
// Backpressure: holds mem_req/addr/wdata stable until mem_ack; start ignored while busy.
module reg_ctx_engine
  import reg_ctx_engine_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [NUM_REGS-1:0] mask,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   end_addr,
  output logic [IDX_W-1:0]    rf_read_index,
  input  logic [DATA_W-1:0]   rf_read_data,
  output logic                rf_write_enable,
  output logic [IDX_W-1:0]    rf_write_index,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [IDX_W-1:0]    cur;
  logic                cur_any;
  logic [NUM_REGS-1:0] pending_clr;

  // Save walks upward from the lowest register, restore walks back down from the highest.
  reg_mask_pick u_pick (
    .mask  (pending_q),
    .dir   (op_q),
    .index (cur),
    .any   (cur_any)
  );

  assign pending_clr = pending_q & ~idx_bit(cur);

  // The address counter is left untouched after DONE, so it doubles as end_addr.
  assign end_addr = addr_q;

  // State and datapath registers; reset abandons any outstanding memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      op_q      <= OP_SAVE;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      data_q    <= data_d;
    end
  end

  // Next-state and port drive; every output is zero outside the state that uses it.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    addr_d          = addr_q;
    op_d            = op_q;
    data_d          = data_q;
    busy            = (state_q != ST_IDLE);
    done            = 1'b0;
    rf_read_index   = '0;
    rf_write_enable = 1'b0;
    rf_write_index  = '0;
    rf_write_data   = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pending_d = mask;
          addr_d    = base_addr;
          op_d      = op;
          if (mask == '0)          state_d = ST_DONE;
          else if (op == OP_SAVE)  state_d = ST_CAP;
          else                     state_d = ST_MEM;
        end
      end

      ST_CAP: begin
        rf_read_index = cur;
        data_d        = rf_read_data;
        addr_d        = addr_q - ADDR_W'(1);
        state_d       = ST_MEM;
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (op_q == OP_SAVE) begin
          mem_we    = 1'b1;
          mem_wdata = data_q;
          if (mem_ack) begin
            pending_d = pending_clr;
            state_d   = (pending_clr == '0) ? ST_DONE : ST_CAP;
          end
        end else if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        // cur_any guards against ever writing the zero register.
        rf_write_enable = cur_any;
        rf_write_index  = cur;
        rf_write_data   = data_q;
        addr_d          = addr_q + ADDR_W'(1);
        pending_d       = pending_clr;
        state_d         = (pending_clr == '0) ? ST_DONE : ST_MEM;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/reg_ctx_engine.md
# reg_ctx_engine

Context save/restore engine for the AudioX 24-bit core. On a start command it walks a 15-bit register mask and either spills the selected general registers (indices 1..15; index 0 is constant zero) to data memory as a descending stack, or refills them from memory. It sits beside the register file: it is the bulk reader of the file's read port and the bulk writer of its write port, and it takes both ports over while busy. It serves call/interrupt entry and exit.

## Interface
- DATA_W, 24, register and memory word width
- IDX_W, 4, register index width
- ADDR_W, 24, word address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- op  in  1  0 = save, 1 = restore
- mask  in  15  bit i selects register index i+1
- base_addr  in  ADDR_W  starting stack address
- busy  out  1  engine owns register file and memory port
- done  out  1  one-cycle completion pulse
- end_addr  out  ADDR_W  final stack address, valid from done until next start
- rf_read_index  out  IDX_W  register file read index
- rf_read_data  in  DATA_W  combinational read data
- rf_write_enable / rf_write_index / rf_write_data  out  1 / IDX_W / DATA_W  register file write port
- mem_req, mem_we  out  1  request, 1 = write
- mem_addr, mem_wdata  out  ADDR_W, DATA_W
- mem_ack  in  1  completes request; may arrive in first req cycle
- mem_rdata  in  DATA_W  valid with mem_ack

## Operation
- States: IDLE, CAP, MEM, WB, DONE.
- IDLE + start: latch mask into pending, base_addr into addr, op. If mask == 0 go DONE; else go CAP (save) or MEM (restore). start while not IDLE is ignored.
- Save order: lowest set pending bit first. CAP: rf_read_index = cur, latch rf_read_data, addr <= addr - 1 → MEM.
- Save MEM: mem_req=1, mem_we=1, mem_addr = addr, mem_wdata = latched value; hold all stable until mem_ack. On ack clear bit; pending empty → DONE, else CAP.
- Restore order: highest set pending bit first. MEM: mem_req=1, mem_we=0, mem_addr = addr; on ack latch mem_rdata → WB.
- Restore WB: rf_write_enable=1, rf_write_index = cur, rf_write_data = latched; addr <= addr + 1; clear bit; pending empty → DONE, else MEM.
- DONE: done=1, end_addr = addr, → IDLE. busy is high from the cycle after start through the DONE cycle.
- Save then restore with the same mask and base = end_addr returns every register and ends at the original base.
- Address arithmetic is modulo 2^ADDR_W (0x000000 − 1 = 0xFFFFFF).
- Restoring sp (index 1) overwrites the file only. The internal addr counter is unaffected.
- rf_write_enable is never asserted with index 0. It is 0 in every state except WB.

## Timing
- Reset (async assert): state IDLE, pending 0. busy, done, mem_req, mem_we and rf_write_enable are 0. All index, address and data outputs are 0. An outstanding memory request is abandoned.
- Zero-wait memory: n selected registers give done in cycle T+1+2n after the start cycle T. Each mem_ack wait cycle adds one.
- rf_read_index is held at 0 outside CAP.

## Structure
- Shared package: DATA_W, IDX_W, NUM_REGS = 15, state enum, register index constants (SP=1, FP=2, RA=3, A0=4, A1=5, M0=6, M1=7, RV=8, V0=9, V1=10, P0..P4 = 11..15).
- One sub-module, reg_mask_pick: combinational lowest/highest-set-bit picker over the 15-bit mask. Inputs are mask and dir; outputs are index and any.

## Test plan
- Save, mask 0x0007, base 0x000100, sp/fp/ra = 0x111111/0x222222/0x333333, zero-wait ack → mem[0x0000FF]=0x111111, [0x0000FE]=0x222222, [0x0000FD]=0x333333. end_addr 0x0000FD, done at T+7.
- Restore, mask 0x0007, base 0x0000FD from that memory → writes index 3, then 2, then 1 with the original values. end_addr 0x000100.
- mask 0 → no mem_req, no rf write, done at T+1, end_addr = base.
- mem_ack delayed 3 cycles per request, with a start pulse injected mid-operation → req, addr and wdata stay stable while waiting. The second start is ignored and the result equals the zero-wait case.
- rst_n low after second register of a 4-register save → all outputs 0 immediately. A new start after release completes normally.
- Save, mask 0x0001, base 0x000000 → write at 0xFFFFFF, end_addr 0xFFFFFF. Restore from there returns end_addr 0x000000.
